// File: rtl/uart_apb_master.sv
// APB3 initiator: converts a valid/ready command stream into single SETUP/ACCESS transfers
// towards the UART register slave and returns data/error on a valid/ready response channel.
module uart_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Last ACCESS cycle index before the abort fires; unused when the timeout is disabled.
    localparam logic [7:0] WAIT_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

    state_t                state, state_d;
    logic [7:0]            wait_cnt, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;
    logic                  pwrite_d, psel_d, penable_d;
    logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        // NOTE: every signal assigned here gets a hold default first, so no path can infer a latch.
        state_d       = state;
        wait_cnt_d    = wait_cnt;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        pwrite_d      = pwrite;
        psel_d        = psel;
        penable_d     = penable;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pwrite_d  = cmd_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // A slave answering on the abort edge still wins over the timeout.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt == WAIT_LAST) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling the pre-edge values.
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            pwrite      <= pwrite_d;
            psel        <= psel_d;
            penable     <= penable_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Scoreboard bench for uart_apb_master: a stimulus process queues commands and expected
// responses, a slave model answers APB, and a response monitor checks results and latency.
module tb_uart_apb_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr, busy;

    uart_apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
        int          hold;
        int          acc_cyc;
    } txn_t;

    txn_t plan_q[$];
    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   in_rsp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input bit err, input int waits, input int hold);
        txn_t t;
        t.write = w;  t.addr = a;  t.wdata = wd;  t.rdata = rd;
        t.slverr = err;  t.waits = waits;  t.hold = hold;  t.acc_cyc = 0;
        return t;
    endfunction

    // Reference model: result and latency from the slave's wait count alone.
    function automatic bit model_timeout(input txn_t t);
        return t.waits >= TO;
    endfunction

    function automatic int model_latency(input txn_t t);
        return 2 + ((t.waits < TO) ? t.waits : TO - 1);
    endfunction

    // APB slave model: answers each transfer after the planned number of wait cycles.
    initial begin
        txn_t cur;
        int   k;
        bit   active;
        active = 1'b0;
        k = 0;
        pready = 1'b0;  prdata = '0;  pslverr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (penable) check("penable_implies_psel", 64'(psel), 64'd1);
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
            if (psel && !penable) begin
                check("setup_has_command", 64'(plan_q.size() > 0), 64'd1);
                active = (plan_q.size() > 0);
                if (active) begin
                    cur = plan_q.pop_front();
                    k = 0;
                    check("setup_paddr", 64'(paddr), 64'(cur.addr));
                    check("setup_pwrite", 64'(pwrite), 64'(cur.write));
                    check("setup_pwdata", 64'(pwdata), cur.write ? 64'(cur.wdata) : 64'd0);
                end
            end else if (psel && penable && active) begin
                check("access_stable", {paddr, pwdata, pwrite},
                      {cur.addr, cur.write ? cur.wdata : 32'd0, cur.write});
                if (k == cur.waits) begin
                    pready  = 1'b1;
                    prdata  = cur.rdata;
                    pslverr = cur.slverr;
                end
                k++;
            end else if (!psel) begin
                active = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response and drives rsp_ready.
    initial begin
        txn_t        e;
        logic [31:0] s_rdata;
        logic        s_err, s_to;
        int          hold_left;
        bit          tmo;
        rsp_ready = 1'b0;
        hold_left = 0;
        s_rdata = '0;  s_err = 1'b0;  s_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                in_rsp = 1'b0;
                rsp_ready = 1'b0;
            end else if (in_rsp && rsp_ready) begin
                check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
                check("post_hs_cmd_ready", 64'(cmd_ready), 64'd1);
                check("post_hs_psel", 64'(psel), 64'd0);
                in_rsp = 1'b0;
                rsp_ready = 1'b0;
            end else if (in_rsp) begin
                check("rsp_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
                      {1'b1, s_rdata, s_err, s_to});
                check("stall_cmd_ready_psel", {cmd_ready, psel}, 2'b00);
                if (hold_left > 0) hold_left--;
                rsp_ready = (hold_left == 0);
            end else if (rsp_valid) begin
                check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    tmo = model_timeout(e);
                    check("rsp_rdata", 64'(rsp_rdata), (e.write || tmo) ? 64'd0 : 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), tmo ? 64'd1 : 64'(e.slverr));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
                    check("rsp_latency", 64'(cyc - e.acc_cyc), 64'(model_latency(e)));
                    check("rsp_psel_low", {psel, penable}, 2'b00);
                    s_rdata = rsp_rdata;  s_err = rsp_err;  s_to = rsp_timeout;
                    hold_left = e.hold;
                    in_rsp = 1'b1;
                    rsp_ready = (hold_left == 0);
                end
            end
        end
    end

    // Presents one command from a negedge; returns at the negedge after acceptance.
    task automatic issue(input txn_t t, input bit b2b, input bit expect_rsp);
        int bound;
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        bound = 0;
        while (!cmd_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        check("cmd_accepted_in_time", 64'(cmd_ready), 64'd1);
        if (!cmd_ready) finish_bench();
        t.acc_cyc = cyc + 1;
        plan_q.push_back(t);
        if (expect_rsp) exp_q.push_back(t);
        @(negedge clk);
        if (!b2b) cmd_valid = 1'b0;
    endtask

    initial begin
        txn_t t;
        int   bound;
        int   r;
        int   pick;
        cmd_valid = 1'b0;  cmd_write = 1'b0;  cmd_addr = '0;  cmd_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 67'd0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 35'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        issue(mk(1, 32'h0C, 32'h1B, 32'hDEAD_BEEF, 0, 0, 0), 0, 1);
        repeat (2) @(negedge clk);
        issue(mk(0, 32'h14, 32'h0, 32'h60, 0, 2, 1), 0, 1);
        issue(mk(1, 32'h00, 32'h41, 32'h0, 1, 1, 0), 0, 1);
        issue(mk(1, 32'h04, 32'h03, 32'h0, 0, 0, 0), 0, 1);
        issue(mk(0, 32'h20, 32'h0, 32'h1234_5678, 0, 1000, 2), 0, 1);
        issue(mk(0, 32'h08, 32'h0, 32'hA5, 0, TO - 1, 0), 0, 1);
        issue(mk(1, 32'h0C, 32'h77, 32'h0, 0, 0, 5), 1, 1);
        issue(mk(0, 32'h14, 32'h0, 32'h5A, 0, 0, 0), 0, 1);

        // Reset during ACCESS: the in-flight read is dropped without a response.
        issue(mk(0, 32'h18, 32'h0, 32'h99, 0, 10, 0), 0, 0);
        bound = 0;
        while (!(psel && penable) && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        check("reached_access", {psel, penable}, 2'b11);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", {psel, penable, rsp_valid, busy}, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        issue(mk(1, 32'h0C, 32'h1B, 32'h0, 0, 1, 0), 0, 1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) pick = r % 4;
            else begin
                case ($urandom_range(0, 3))
                    0: pick = TO - 2;
                    1: pick = TO - 1;
                    2: pick = TO;
                    default: pick = 40;
                endcase
            end
            t = mk(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                   $urandom, 1'($urandom_range(0, 3) == 0), pick, $urandom_range(0, 3));
            r = $urandom_range(0, 2);
            issue(t, r == 0, 1);
            if (r != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cmd_valid = 1'b0;
        bound = 0;
        while ((exp_q.size() != 0 || in_rsp) && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        check("responses_drained", 64'(exp_q.size()), 64'd0);
        check("final_idle", {busy, cmd_ready}, 2'b01);
        finish_bench();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
